// File: rtl/serial_deser_pkg.sv
// Shared state encoding, line levels and helpers for serial_frame_deserializer.
// The parity build is selected in the top with SERIAL_DESER_PARITY_EN.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } deser_state_e;

  localparam logic START_BIT_LVL = 1'b0;
  localparam logic STOP_BIT_LVL  = 1'b1;

  // A 1-bit counter is still needed when W is small enough to round down to 0.
  function automatic int deser_cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  // Even parity: data reduction XOR and parity bit must cancel.
  function automatic logic even_parity_bad(input logic data_xor, input logic par_bit);
    return data_xor ^ par_bit;
  endfunction

endpackage

// File: rtl/deser_shift_core.sv
// W-bit shift register for the deserializer; shifts right (LSB-first) or
// left (MSB-first) on each enabled cycle.
module deser_shift_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         lsb_first,
  input  logic         sin,
  output logic [W-1:0] sh
);

  // Serial-to-parallel shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= {W{1'b0}};
    end else if (shift_en) begin
      if (lsb_first) begin
        sh <= {sin, sh[W-1:1]};
      end else begin
        sh <= {sh[W-2:0], sin};
      end
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Start/data/stop frame receiver with valid/ready word output and error flags.
// Define SERIAL_DESER_PARITY_EN to add an even-parity bit and parity_err.
module serial_frame_deserializer
  import serial_deser_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         lsb_first,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         framing_err,
`ifdef SERIAL_DESER_PARITY_EN
  output logic         parity_err,
`endif
  output logic         overrun
);

  localparam int CW = deser_cnt_width(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_DATA = ST_DATA;
  localparam logic [1:0] S_PAR  = ST_PAR;
  localparam logic [1:0] S_STOP = ST_STOP;

`ifdef SERIAL_DESER_PARITY_EN
  localparam logic [1:0] S_AFTER_DATA = S_PAR;
`else
  localparam logic [1:0] S_AFTER_DATA = S_STOP;
`endif

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          dir_r;
  logic [W-1:0]  sh_s;
  logic          start_s;
  logic          shift_en_s;
  logic          stop_cyc_s;
  logic          par_bad_s;
  logic          good_s;
  logic          load_s;

  assign start_s    = sin_valid && (state_r == S_IDLE) && (sin == START_BIT_LVL);
  assign shift_en_s = sin_valid && (state_r == S_DATA);
  assign stop_cyc_s = sin_valid && (state_r == S_STOP);

  deser_shift_core #(
    .W (W)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en_s),
    .lsb_first (dir_r),
    .sin       (sin),
    .sh        (sh_s)
  );

`ifdef SERIAL_DESER_PARITY_EN
  logic par_bit_r;

  // Parity bit capture
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit_r <= 1'b0;
    end else if (sin_valid && (state_r == S_PAR)) begin
      par_bit_r <= sin;
    end
  end

  assign par_bad_s = stop_cyc_s && even_parity_bad(^sh_s, par_bit_r);
`else
  assign par_bad_s = 1'b0;
`endif

  // A good frame can still land when the consumer empties the slot this cycle.
  assign good_s = stop_cyc_s && (sin == STOP_BIT_LVL) && !par_bad_s;
  assign load_s = good_s && (!out_valid || out_ready);

  // Frame sequencing; S_PAR falls through to STOP in either build
  always_comb begin
    state_nxt_s = state_r;
    if (sin_valid) begin
      case (state_r)
        S_IDLE: begin
          if (sin == START_BIT_LVL) begin
            state_nxt_s = S_DATA;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_r == LAST_BIT) begin
            state_nxt_s = S_AFTER_DATA;
          end else begin
            state_nxt_s = S_DATA;
          end
        end
        S_PAR:   state_nxt_s = S_STOP;
        S_STOP:  state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, bit counter, latched direction and busy
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      dir_r   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != S_IDLE);
      if (start_s) begin
        dir_r <= lsb_first;
        cnt_r <= {CW{1'b0}};
      end else if (shift_en_s && (cnt_r != LAST_BIT)) begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  // Output slot and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= {W{1'b0}};
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (load_s) begin
        out_data  <= sh_s;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (good_s && !load_s) begin
        overrun <= 1'b1;
      end
      framing_err <= stop_cyc_s && (sin != STOP_BIT_LVL);
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  // Parity error pulse, raised in the stop cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_bad_s;
    end
  end
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer (W=8): directed frames
// followed by randomized frames against a frame-level transmitter/slot model.
module tb_serial_frame_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sin = 1'b1;
  logic         sin_valid = 1'b0;
  logic         lsb_first = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         framing_err;
  logic         overrun;
`ifdef SERIAL_DESER_PARITY_EN
  logic         parity_err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  // Reference model of the output slot
  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_data  = '0;
  logic         exp_ovr   = 1'b0;
  logic         gaps_on   = 1'b0;

  always #5 clk = ~clk;

  serial_frame_deserializer #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .lsb_first   (lsb_first),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .framing_err (framing_err),
`ifdef SERIAL_DESER_PARITY_EN
    .parity_err  (parity_err),
`endif
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word value of a bit stream: k-th sent bit weighs 2^k (LSB-first) or 2^(W-1-k).
  function automatic logic [W-1:0] word_of(input logic [W-1:0] seq, input logic lsb);
    int val = 0;
    for (int k = 0; k < W; k++) begin
      val += int'(seq[k]) * (1 << (lsb ? k : (W - 1 - k)));
    end
    return W'(val);
  endfunction

  // Bit stream that transmits a word in the given order.
  function automatic logic [W-1:0] seq_of(input logic [W-1:0] word, input logic lsb);
    logic [W-1:0] s;
    for (int k = 0; k < W; k++) begin
      s[k] = lsb ? word[k] : word[W-1-k];
    end
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    sin_valid = 1'b0;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_ovr   = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    if (gaps_on) begin
      repeat ($urandom_range(0, 2)) begin
        sin = 1'($urandom);
        sin_valid = 1'b0;
        out_ready = 1'b0;
        step();
      end
    end
    sin = b;
    sin_valid = 1'b1;
    out_ready = rdy;
    step();
    sin_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic consume(input string tag);
    check({tag, "_pre_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    out_ready = 1'b1;
    sin_valid = 1'b0;
    step();
    out_ready = 1'b0;
    exp_valid = 1'b0;
    check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic send_frame(input logic [W-1:0] seq, input logic lsb, input logic stop_b,
                            input logic rdy_stop, input logic par_flip, input string tag);
    logic [W-1:0] word;
    logic         par_ok;
    logic         good;
    word = word_of(seq, lsb);
    lsb_first = lsb;
    send_bit(1'b0, 1'b0);
    lsb_first = ~lsb;
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    check({tag, "_ferr_idle"}, {31'd0, framing_err}, 32'd0);
    for (int k = 0; k < W; k++) begin
      send_bit(seq[k], 1'b0);
    end
    check({tag, "_busy_data"}, {31'd0, busy}, 32'd1);
`ifdef SERIAL_DESER_PARITY_EN
    send_bit((^seq) ^ par_flip, 1'b0);
`endif
    par_ok = ~par_flip;
    send_bit(stop_b, rdy_stop);
    good = stop_b && par_ok;
    if (good && (!exp_valid || rdy_stop)) begin
      exp_data  = word;
      exp_valid = 1'b1;
    end else if (good) begin
      exp_ovr = 1'b1;
    end else if (rdy_stop) begin
      exp_valid = 1'b0;
    end
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
    check({tag, "_ferr"}, {31'd0, framing_err}, {31'd0, ~stop_b});
`ifdef SERIAL_DESER_PARITY_EN
    check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, ~par_ok});
`endif
  endtask

  initial begin
    step();
    do_reset();
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, framing_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);

    // Bits 0,0,0,1,1,1,1,0 in both orders
    send_frame(8'b0111_1000, 1'b0, 1'b1, 1'b0, 1'b0, "msb");
    check("msb_1e", 32'(out_data), 32'h1E);
    consume("msb");
    send_frame(8'b0111_1000, 1'b1, 1'b1, 1'b0, 1'b0, "lsb");
    check("lsb_78", 32'(out_data), 32'h78);
    consume("lsb");

    // Back-to-back, second word dropped
    do_reset();
    send_frame(seq_of(8'h1E, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0, "b2b_a");
    send_frame(seq_of(8'h55, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0, "b2b_b");
    check("b2b_ovr", {31'd0, overrun}, 32'd1);
    check("b2b_held", 32'(out_data), 32'h1E);

    // Back-to-back, slot emptied as the second word lands
    do_reset();
    send_frame(seq_of(8'h1E, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0, "hs_a");
    send_frame(seq_of(8'h55, 1'b0), 1'b0, 1'b1, 1'b1, 1'b0, "hs_b");
    check("hs_no_ovr", {31'd0, overrun}, 32'd0);
    check("hs_55", 32'(out_data), 32'h55);
    consume("hs");

    // Framing error, then recovery
    send_frame(seq_of(8'h3C, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, "ferr");
    sin = 1'b1;
    sin_valid = 1'b1;
    step();
    sin_valid = 1'b0;
    check("ferr_one_pulse", {31'd0, framing_err}, 32'd0);
    check("ferr_idle_busy", {31'd0, busy}, 32'd0);
    send_frame(seq_of(8'hA5, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0, "a5");
    check("a5_data", 32'(out_data), 32'hA5);
    consume("a5");

    // Reset after four data bits
    lsb_first = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_bit(1'b1, 1'b0);
    end
    do_reset();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    send_frame(seq_of(8'hC3, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0, "c3");
    check("c3_data", 32'(out_data), 32'hC3);
    consume("c3");

`ifdef SERIAL_DESER_PARITY_EN
    do_reset();
    send_frame(seq_of(8'h1E, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0, "par_ok");
    check("par_ok_1e", 32'(out_data), 32'h1E);
    consume("par_ok");
    send_frame(seq_of(8'h1E, 1'b0), 1'b0, 1'b1, 1'b0, 1'b1, "par_bad");
    check("par_bad_drop", {31'd0, out_valid}, 32'd0);
`endif

    // Randomized frames with strobe gaps
    do_reset();
    gaps_on = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] wd;
      logic         lsb;
      logic         stp;
      logic         rdy;
      logic         pf;
      wd  = W'($urandom);
      lsb = 1'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      rdy = 1'($urandom);
`ifdef SERIAL_DESER_PARITY_EN
      pf  = ($urandom_range(0, 4) == 0);
`else
      pf  = 1'b0;
`endif
      send_frame(seq_of(wd, lsb), lsb, stp, rdy, pf, "rnd");
      if ($urandom_range(0, 2) == 0) begin
        consume("rnd");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
